// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types used by the MEM-stage controller.
package cpu_types_pkg;

    localparam int WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_ACCESS,
        MS_DONE
    } memstate_t;

endpackage

// File: rtl/link_reg.sv
// LL/SC link register: remembers the address of the last LL and whether the
// reservation is still intact. A matching snoop invalidate wins over everything,
// then an LL set, then a store to the linked address.
module link_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic              snoop_i,
    input  logic [WORD_W-1:0] snoop_addr_i,
    output logic              link_valid_o,
    output logic [WORD_W-1:0] link_addr_o
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] addr_q, addr_d;

    // Prioritised next-state: snoop kill, then LL set, then store-to-link clear.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (snoop_i && (snoop_addr_i == addr_q)) begin
            valid_d = 1'b0;
        end else if (set_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end else if (clr_i && (addr_i == addr_q)) begin
            valid_d = 1'b0;
        end
    end

    // Link state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign link_valid_o = valid_q;
    assign link_addr_o  = addr_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller. Launches dcache requests for
// LW/SW/LL/SC, stalls the front of the pipe until dhit, registers the load
// result, and tells the MEM/WB latch when to capture or bubble.
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter bit LINK_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              op_valid,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              LL_in,
    input  logic              SC_in,
    input  logic [WORD_W-1:0] addr_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic              flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] load_out,
    output logic              mem_stall,
    output logic              memwb_wen,
    output logic              memwb_flush
);

    memstate_t         state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ll_q, ll_d;
    logic              sc_q, sc_d;
    logic              flush_q, flush_d;
    logic [WORD_W-1:0] load_q, load_d;

    logic              link_valid;
    logic [WORD_W-1:0] link_addr;
    logic              link_set;
    logic              link_clr;
    logic              mem_op;
    logic              sc_miss;

    assign mem_op  = op_valid && (MemRead_in || MemWrite_in);
    // A failed SC never touches the cache; without a link register SC always succeeds.
    assign sc_miss = LINK_EN && SC_in && (!link_valid || (link_addr != addr_in));

    generate
        if (LINK_EN) begin : g_link
            link_reg #(.WORD_W(WORD_W)) u_link (
                .clk_i        (CLK),
                .rst_ni       (nRST),
                .set_i        (link_set),
                .clr_i        (link_clr),
                .addr_i       (addr_in),
                .snoop_i      (ccinv),
                .snoop_addr_i (ccsnoopaddr),
                .link_valid_o (link_valid),
                .link_addr_o  (link_addr)
            );
        end else begin : g_nolink
            assign link_valid = 1'b0;
            assign link_addr  = '0;
        end
    endgenerate

    // Next-state, latched-op capture and all handshake outputs.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        ll_d        = ll_q;
        sc_d        = sc_q;
        flush_d     = flush_q;
        load_d      = load_q;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        dmemaddr    = '0;
        dmemstore   = '0;
        mem_stall   = 1'b0;
        memwb_wen   = 1'b1;
        memwb_flush = 1'b0;
        link_set    = 1'b0;
        link_clr    = 1'b0;
        unique case (state_q)
            MS_IDLE: begin
                if (flush) begin
                    memwb_flush = 1'b1;
                    memwb_wen   = 1'b0;
                end else if (mem_op && sc_miss) begin
                    load_d = '0;
                end else if (mem_op) begin
                    state_d   = MS_ACCESS;
                    rd_d      = MemRead_in;
                    wr_d      = MemWrite_in;
                    ll_d      = LL_in;
                    sc_d      = SC_in;
                    flush_d   = 1'b0;
                    mem_stall = 1'b1;
                    memwb_wen = 1'b0;
                end
            end
            MS_ACCESS: begin
                // The cache op cannot be aborted; a flush is only remembered.
                dmemREN   = rd_q;
                dmemWEN   = wr_q;
                dmemaddr  = addr_in;
                dmemstore = store_in;
                mem_stall = 1'b1;
                memwb_wen = 1'b0;
                if (flush) begin
                    flush_d = 1'b1;
                end
                if (dhit) begin
                    state_d  = MS_DONE;
                    load_d   = sc_q ? WORD_W'(1) : dmemload;
                    link_set = ll_q;
                    link_clr = wr_q;
                end
            end
            MS_DONE: begin
                if (flush_q || flush) begin
                    memwb_flush = 1'b1;
                    memwb_wen   = 1'b0;
                end
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // FSM state, latched op and load-result registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= MS_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ll_q    <= 1'b0;
            sc_q    <= 1'b0;
            flush_q <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ll_q    <= ll_d;
            sc_q    <= sc_d;
            flush_q <= flush_d;
            load_q  <= load_d;
        end
    end

    assign load_out = load_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a completion scoreboard.
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        op_valid, MemRead_in, MemWrite_in, LL_in, SC_in;
    logic [31:0] addr_in, store_in;
    logic        flush, dhit;
    logic [31:0] dmemload;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, load_out;
    logic        mem_stall, memwb_wen, memwb_flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        flushed;
        int          stalls;
        int          rens;
        int          wens;
    } exp_t;

    exp_t exp_q[$];

    mem_stage_ctrl #(.WORD_W(32), .LINK_EN(1'b1)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .op_valid    (op_valid),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .LL_in       (LL_in),
        .SC_in       (SC_in),
        .addr_in     (addr_in),
        .store_in    (store_in),
        .flush       (flush),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .load_out    (load_out),
        .mem_stall   (mem_stall),
        .memwb_wen   (memwb_wen),
        .memwb_flush (memwb_flush)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_op();
        op_valid    = 1'b0;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        LL_in       = 1'b0;
        SC_in       = 1'b0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic ll, input logic sc,
                            input logic [31:0] addr, input logic [31:0] st);
        op_valid    = 1'b1;
        MemRead_in  = rd;
        MemWrite_in = wr;
        LL_in       = ll;
        SC_in       = sc;
        addr_in     = addr;
        store_in    = st;
    endtask

    // Full access: push expectation, hold op, dhit on ACCESS cycle 'lat'.
    task automatic mem_access(input string tag, input logic rd, input logic wr, input logic ll,
                              input logic sc, input logic [31:0] addr, input logic [31:0] st,
                              input int lat, input logic [31:0] rdata, input logic [31:0] exp_load,
                              input logic flush_mid);
        exp_t e;
        e.data    = exp_load;
        e.flushed = flush_mid;
        e.stalls  = lat + 1;
        e.rens    = rd ? lat : 0;
        e.wens    = wr ? lat : 0;
        exp_q.push_back(e);
        drive_op(rd, wr, ll, sc, addr, st);
        tick();
        for (int i = 1; i <= lat; i++) begin
            if (i == 1) begin
                chk({tag, "_addr"}, dmemaddr, addr);
                chk({tag, "_store"}, dmemstore, st);
                if (flush_mid) flush = 1'b1;
            end
            if (i == lat) begin
                dhit     = 1'b1;
                dmemload = rdata;
            end
            tick();
            flush = 1'b0;
        end
        dhit     = 1'b0;
        dmemload = '0;
        clear_op();
        tick();
    endtask

    // SC with a broken reservation: no request, no stall, result 0.
    task automatic sc_fail(input string tag, input logic [31:0] addr);
        drive_op(1'b0, 1'b1, 1'b0, 1'b1, addr, 32'h5555_0000);
        #1;
        chk({tag, "_stall"}, {31'b0, mem_stall}, 32'd0);
        chk({tag, "_wen"}, {31'b0, dmemWEN}, 32'd0);
        chk({tag, "_memwb_wen"}, {31'b0, memwb_wen}, 32'd1);
        tick();
        clear_op();
        chk({tag, "_load"}, load_out, 32'd0);
        chk({tag, "_idle"}, {31'b0, dmemWEN}, 32'd0);
    endtask

    // Completion monitor: counts stall/request cycles, compares on stall release.
    int   stall_cnt = 0;
    int   ren_cnt   = 0;
    int   wen_cnt   = 0;
    logic prev_stall = 1'b0;

    always @(negedge CLK) begin
        if (!nRST) begin
            prev_stall = 1'b0;
            stall_cnt  = 0;
            ren_cnt    = 0;
            wen_cnt    = 0;
        end else if (mem_stall) begin
            stall_cnt  = stall_cnt + 1;
            ren_cnt    = ren_cnt + int'(dmemREN);
            wen_cnt    = wen_cnt + int'(dmemWEN);
            prev_stall = 1'b1;
        end else if (prev_stall) begin
            prev_stall = 1'b0;
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_load", load_out, e.data);
                chk("done_memwb_wen", {31'b0, memwb_wen}, {31'b0, ~e.flushed});
                chk("done_memwb_flush", {31'b0, memwb_flush}, {31'b0, e.flushed});
                chk("done_stall_cycles", stall_cnt, e.stalls);
                chk("done_ren_cycles", ren_cnt, e.rens);
                chk("done_wen_cycles", wen_cnt, e.wens);
            end
            stall_cnt = 0;
            ren_cnt   = 0;
            wen_cnt   = 0;
        end
    end

    initial begin
        nRST        = 1'b0;
        clear_op();
        addr_in     = '0;
        store_in    = '0;
        flush       = 1'b0;
        dhit        = 1'b0;
        dmemload    = '0;
        ccinv       = 1'b0;
        ccsnoopaddr = '0;
        repeat (2) tick();
        nRST = 1'b1;
        tick();

        // Reset state
        chk("rst_ren", {31'b0, dmemREN}, 32'd0);
        chk("rst_wen", {31'b0, dmemWEN}, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_memwb_wen", {31'b0, memwb_wen}, 32'd1);
        chk("rst_memwb_flush", {31'b0, memwb_flush}, 32'd0);
        chk("rst_load", load_out, 32'd0);

        // LW, dhit on third ACCESS cycle
        mem_access("lw", 1, 0, 0, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        // SW, dhit on first ACCESS cycle
        mem_access("sw", 0, 1, 0, 0, 32'h200, 32'h1234, 1, 32'h0, 32'h0, 1'b0);

        // LL then SC succeeds; repeated SC fails
        mem_access("ll1", 1, 0, 1, 0, 32'h300, 32'h0, 1, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
        mem_access("sc1", 0, 1, 0, 1, 32'h300, 32'h77, 2, 32'h0, 32'd1, 1'b0);
        sc_fail("sc_repeat", 32'h300);

        // Snoop to the linked address breaks the reservation
        mem_access("ll2", 1, 0, 1, 0, 32'h300, 32'h0, 1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
        ccinv       = 1'b1;
        ccsnoopaddr = 32'h300;
        tick();
        ccinv = 1'b0;
        sc_fail("sc_snooped", 32'h300);

        // Snoop to a different address leaves it intact
        mem_access("ll3", 1, 0, 1, 0, 32'h300, 32'h0, 1, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0);
        ccinv       = 1'b1;
        ccsnoopaddr = 32'h304;
        tick();
        ccinv = 1'b0;
        mem_access("sc_other_snoop", 0, 1, 0, 1, 32'h300, 32'h99, 1, 32'h0, 32'd1, 1'b0);

        // Flush during ACCESS: access completes, MEM/WB gets a bubble
        mem_access("lw_flush", 1, 0, 0, 0, 32'h400, 32'h0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);

        // Flushed LL still sets the link
        mem_access("ll_flush", 1, 0, 1, 0, 32'h500, 32'h0, 1, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 1'b1);
        mem_access("sc_after_flush", 0, 1, 0, 1, 32'h500, 32'h42, 1, 32'h0, 32'd1, 1'b0);

        // Flush in IDLE: nothing launched
        drive_op(1, 0, 0, 0, 32'h440, 32'h0);
        flush = 1'b1;
        #1;
        chk("idle_flush_memwb_flush", {31'b0, memwb_flush}, 32'd1);
        chk("idle_flush_ren", {31'b0, dmemREN}, 32'd0);
        chk("idle_flush_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        flush = 1'b0;
        clear_op();
        #1;
        chk("idle_flush_after_ren", {31'b0, dmemREN}, 32'd0);
        chk("idle_flush_after_stall", {31'b0, mem_stall}, 32'd0);

        // Reset in the middle of an access drops requests and the link
        mem_access("ll4", 1, 0, 1, 0, 32'h300, 32'h0, 1, 32'h7777_8888, 32'h7777_8888, 1'b0);
        drive_op(1, 0, 0, 0, 32'h600, 32'h0);
        tick();
        chk("pre_rst_ren", {31'b0, dmemREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_ren", {31'b0, dmemREN}, 32'd0);
        chk("mid_rst_wen", {31'b0, dmemWEN}, 32'd0);
        chk("mid_rst_load", load_out, 32'd0);
        clear_op();
        tick();
        nRST = 1'b1;
        tick();
        chk("post_rst_stall", {31'b0, mem_stall}, 32'd0);
        sc_fail("sc_after_rst", 32'h300);

        repeat (2) tick();
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
